// File: rtl/gpio_seq_pkg.sv
// Shared types and constants for the GPIO bit-bang sequencer.
package gpio_seq_pkg;

  // Command opcodes stored in the upper two bits of each command RAM word.
  typedef enum logic [1:0] {
    OpSetData = 2'd0,
    OpSetOe   = 2'd1,
    OpDelay   = 2'd2,
    OpPoll    = 2'd3
  } op_e;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StExec    = 3'd2,
    StDelay   = 3'd3,
    StPollRq  = 3'd4,
    StPollChk = 3'd5,
    StFinish  = 3'd6
  } state_e;

  // CPU-side register word addresses.
  localparam logic [2:0] AddrCtrl     = 3'd0;
  localparam logic [2:0] AddrStatus   = 3'd1;
  localparam logic [2:0] AddrLen      = 3'd2;
  localparam logic [2:0] AddrCmdOp    = 3'd3;
  localparam logic [2:0] AddrCmdArg   = 3'd4;
  localparam logic [2:0] AddrPollMask = 3'd5;
  localparam logic [2:0] AddrPollTmo  = 3'd6;
  localparam logic [2:0] AddrPins     = 3'd7;

  // CTRL register bit positions.
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;
  localparam int unsigned CtrlClrBit   = 2;

  // GPIO peripheral word addresses.
  localparam logic [2:0] GpioAddrData = 3'd2;
  localparam logic [2:0] GpioAddrOe   = 3'd4;

  // Width of one command word: {opcode, 32-bit argument}.
  localparam int unsigned CmdWidth = 34;

endpackage

// File: rtl/gpio_seq_ram.sv
// Command RAM: one write port from the CPU loader, one registered read port for the sequencer.
module gpio_seq_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Storage array; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data holds its value between fetches so the current command stays visible.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  // Registered read output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gpio_seq_ctrl.sv
// GPIO bit-bang sequencer: runs a CPU-loaded command program against the GPIO slave port.
module gpio_seq_ctrl
  import gpio_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  output logic [2:0]  avm_gpio_address,
  output logic        avm_gpio_write,
  output logic        avm_gpio_read,
  output logic [31:0] avm_gpio_writedata,
  output logic [3:0]  avm_gpio_byteenable,
  input  logic [31:0] avm_gpio_readdata,
  output logic        irq
);

  localparam logic [AW:0]   LenOne = 1;
  localparam logic [AW-1:0] PtrOne = 1;

  state_e          state_q, state_d;
  logic [AW:0]     pc_q, pc_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   ld_ptr_q, ld_ptr_d;
  logic [1:0]      op_stage_q, op_stage_d;
  logic [31:0]     mask_q, mask_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     pins_q, pins_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            ctrl_wr, start, abort, clr;
  logic            ram_we, ram_re;
  logic [CmdWidth-1:0] ram_wdata, ram_rdata;
  op_e             cmd_op;
  logic [31:0]     cmd_arg;
  logic            last_cmd, poll_match, adv;

  assign ctrl_wr = avs_ctrl_write && (avs_ctrl_address == AddrCtrl);
  assign start   = ctrl_wr && avs_ctrl_writedata[CtrlStartBit];
  assign abort   = ctrl_wr && avs_ctrl_writedata[CtrlAbortBit];
  assign clr     = ctrl_wr && avs_ctrl_writedata[CtrlClrBit];

  assign ram_we    = avs_ctrl_write && (avs_ctrl_address == AddrCmdArg) && !busy_q;
  assign ram_wdata = {op_stage_q, avs_ctrl_writedata};
  assign ram_re    = (state_q == StFetch);

  gpio_seq_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .WIDTH(CmdWidth)
  ) u_ram (
    .clk_i  (csi_MCLK_clk),
    .rst_i  (rsi_MRST_reset),
    .we_i   (ram_we),
    .waddr_i(ld_ptr_q),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(pc_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  assign cmd_op     = op_e'(ram_rdata[CmdWidth-1:CmdWidth-2]);
  assign cmd_arg    = ram_rdata[31:0];
  assign last_cmd   = (pc_q == (len_q - LenOne));
  assign poll_match = ((avm_gpio_readdata ^ cmd_arg) & mask_q) == '0;

  // CPU-programmed configuration registers and command loader pointer.
  always_comb begin
    len_d      = len_q;
    ld_ptr_d   = ld_ptr_q;
    op_stage_d = op_stage_q;
    mask_d     = mask_q;
    tmo_d      = tmo_q;
    if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        AddrLen: begin
          if (!busy_q) begin
            len_d    = avs_ctrl_writedata[AW:0];
            ld_ptr_d = '0;
          end
        end
        AddrCmdOp: begin
          if (!busy_q) begin
            op_stage_d = avs_ctrl_writedata[1:0];
          end
        end
        AddrCmdArg: begin
          if (!busy_q) begin
            ld_ptr_d = ld_ptr_q + PtrOne;
          end
        end
        AddrPollMask: mask_d = avs_ctrl_writedata;
        AddrPollTmo:  tmo_d  = avs_ctrl_writedata;
        default: ;
      endcase
    end
  end

  // Sequencer next-state: program execution, status flags and pin capture.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    pins_d    = pins_q;
    adv       = 1'b0;

    if (clr) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            pc_d      = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            state_d   = StFetch;
          end
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        unique case (cmd_op)
          OpSetData, OpSetOe: adv = 1'b1;
          OpDelay: begin
            // The DELAY state is entered only for non-zero counts so arg cycles are added exactly.
            if (cmd_arg == '0) begin
              adv = 1'b1;
            end else begin
              cnt_d   = cmd_arg - 32'd1;
              state_d = StDelay;
            end
          end
          OpPoll: begin
            cnt_d   = tmo_q;
            state_d = StPollRq;
          end
        endcase
      end
      StDelay: begin
        if (cnt_q == '0) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StPollRq: state_d = StPollChk;
      StPollChk: begin
        pins_d = avm_gpio_readdata;
        if (poll_match) begin
          adv = 1'b1;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          cnt_d   = cnt_q - 32'd1;
          state_d = StPollRq;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = !timeout_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (adv) begin
      if (last_cmd) begin
        state_d = StFinish;
      end else begin
        pc_d    = pc_q + LenOne;
        state_d = StFetch;
      end
    end

    // Abort beats everything else and never reports completion.
    if (abort) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      done_d    = clr ? 1'b0 : done_q;
      timeout_d = clr ? 1'b0 : timeout_q;
    end
  end

  // CPU read data mux, registered on the read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_ctrl_read) begin
      case (avs_ctrl_address)
        AddrStatus:   rdata_d = {16'h0, 8'(pc_q), 5'h0, timeout_q, done_q, busy_q};
        AddrLen:      rdata_d = 32'(len_q);
        AddrPollMask: rdata_d = mask_q;
        AddrPollTmo:  rdata_d = tmo_q;
        AddrPins:     rdata_d = pins_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      len_q      <= '0;
      ld_ptr_q   <= '0;
      op_stage_q <= '0;
      mask_q     <= '0;
      tmo_q      <= '0;
      pins_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      ld_ptr_q   <= ld_ptr_d;
      op_stage_q <= op_stage_d;
      mask_q     <= mask_d;
      tmo_q      <= tmo_d;
      pins_q     <= pins_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
    end
  end

  // GPIO master strobes decoded from the current state; write and read are mutually exclusive.
  always_comb begin
    avm_gpio_write     = (state_q == StExec) && ((cmd_op == OpSetData) || (cmd_op == OpSetOe));
    avm_gpio_read      = (state_q == StPollRq);
    avm_gpio_address   = ((state_q == StExec) && (cmd_op == OpSetOe)) ? GpioAddrOe : GpioAddrData;
    avm_gpio_writedata = avm_gpio_write ? cmd_arg : '0;
  end

  assign avm_gpio_byteenable  = 4'hF;
  assign avs_ctrl_waitrequest = 1'b0;
  assign avs_ctrl_readdata    = rdata_q;
  assign irq                  = done_q | timeout_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Self-checking bench for gpio_seq_ctrl: directed scenarios plus random programs vs a timing model.
module tb_gpio_seq_ctrl;

  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_LEN = 3'd2, A_OP = 3'd3;
  localparam logic [2:0] A_ARG = 3'd4, A_MASK = 3'd5, A_TMO = 3'd6, A_PINS = 3'd7;

  typedef struct packed {
    int unsigned t;
    logic        kind;  // 0 write, 1 read
    logic [2:0]  addr;
    logic [31:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  c_addr = '0;
  logic        c_wr = 1'b0, c_rd = 1'b0;
  logic [31:0] c_wdata = '0, c_rdata;
  logic        c_wait;
  logic [2:0]  g_addr;
  logic        g_wr, g_rd;
  logic [31:0] g_wdata;
  logic [3:0]  g_be;
  logic [31:0] g_rdata = '0;
  logic        irq;

  always #5 clk = ~clk;

  gpio_seq_ctrl #(.DEPTH(16), .AW(4)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset      (rst),
    .avs_ctrl_address    (c_addr),
    .avs_ctrl_write      (c_wr),
    .avs_ctrl_read       (c_rd),
    .avs_ctrl_writedata  (c_wdata),
    .avs_ctrl_readdata   (c_rdata),
    .avs_ctrl_waitrequest(c_wait),
    .avm_gpio_address    (g_addr),
    .avm_gpio_write      (g_wr),
    .avm_gpio_read       (g_rd),
    .avm_gpio_writedata  (g_wdata),
    .avm_gpio_byteenable (g_be),
    .avm_gpio_readdata   (g_rdata),
    .irq                 (irq)
  );

  int unsigned n_chk = 0, n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // GPIO slave model: answers each read one cycle later from a scripted queue.
  logic [31:0] rd_vals[$];
  always @(posedge clk) begin
    if (g_rd) begin
      if (rd_vals.size() > 0) g_rdata <= rd_vals.pop_front();
      else g_rdata <= 32'h0;
    end
  end

  // Transaction monitor.
  bit  mon_en = 1'b0;
  tx_t obs_q[$];
  always @(negedge clk) begin
    if (mon_en && (g_wr || g_rd)) begin
      obs_q.push_back('{t: cyc, kind: g_rd, addr: g_addr, data: (g_rd ? 32'h0 : g_wdata)});
      check_eq("strobe_excl", 32'(g_wr & g_rd), 32'h0);
    end
    if (mon_en && !g_wr) check_eq("addr_idle", 32'(g_addr), 32'd2);
  end

  // Program under test and model results.
  int unsigned p_op[$];
  logic [31:0] p_arg[$];
  int unsigned p_miss[$];  // per POLL: non-matching samples before the match
  logic [31:0] p_mask, p_tmo;
  tx_t         exp_q[$];
  int unsigned e_irq_t, e_pc;
  logic        e_timeout;
  logic [31:0] m_pins = '0;

  // Reference model: each command costs fetch+exec (2 cycles); DELAY adds arg; each poll
  // sample adds a request and a check cycle.
  task automatic build_expect();
    int unsigned f;
    int unsigned pi;
    int unsigned miss;
    logic [31:0] want, lowbit, v;
    bit stop;
    f = 0; pi = 0; stop = 0;
    exp_q.delete(); rd_vals.delete();
    e_timeout = 1'b0;
    e_pc = p_op.size() - 1;
    for (int k = 0; k < p_op.size() && !stop; k++) begin
      case (p_op[k])
        0, 1: begin
          exp_q.push_back('{t: f + 1, kind: 1'b0, addr: (p_op[k] == 1) ? 3'd4 : 3'd2,
                            data: p_arg[k]});
          f += 2;
        end
        2: f += 2 + p_arg[k];
        default: begin
          miss = p_miss[pi];
          pi++;
          want = p_arg[k] & p_mask;
          lowbit = p_mask & (~p_mask + 32'd1);
          for (int s = 0; s <= p_tmo; s++) begin
            exp_q.push_back('{t: f + 2 + 2 * s, kind: 1'b1, addr: 3'd2, data: 32'h0});
            if (s < miss) v = ((want ^ lowbit) & p_mask) | ($urandom() & ~p_mask);
            else v = want | ($urandom() & ~p_mask);
            rd_vals.push_back(v);
            m_pins = v;
            if (s == miss) begin
              f += 2 + 2 * (s + 1);
              break;
            end
            if (s == p_tmo) begin
              stop = 1;
              e_timeout = 1'b1;
              e_pc = k;
              e_irq_t = f + 2 + 2 * s + 2;
            end
          end
        end
      endcase
    end
    if (!e_timeout) e_irq_t = f + 1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    c_addr = a; c_wdata = d; c_wr = 1'b1;
    @(negedge clk);
    c_wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    c_addr = a; c_rd = 1'b1;
    @(negedge clk);
    c_rd = 1'b0;
    d = c_rdata;
  endtask

  task automatic load_prog();
    cpu_wr(A_LEN, p_op.size());
    for (int k = 0; k < p_op.size(); k++) begin
      cpu_wr(A_OP, p_op[k]);
      cpu_wr(A_ARG, p_arg[k]);
    end
    cpu_wr(A_MASK, p_mask);
    cpu_wr(A_TMO, p_tmo);
  endtask

  task automatic run_prog(input string tag);
    logic [31:0] d;
    int unsigned t0;
    cpu_wr(A_CTRL, 32'h4);
    load_prog();
    build_expect();
    obs_q.delete();
    mon_en = 1'b1;
    cpu_wr(A_CTRL, 32'h1);
    t0 = cyc;
    while (!irq && (cyc - t0) < 5000) @(negedge clk);
    check_eq({tag, "_irq_t"}, cyc - t0, e_irq_t);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check_eq({tag, "_ntx"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq({tag, "_tx_t"}, obs_q[i].t - t0, exp_q[i].t);
      check_eq({tag, "_tx_kind_addr"}, {28'h0, obs_q[i].kind, obs_q[i].addr},
               {28'h0, exp_q[i].kind, exp_q[i].addr});
      check_eq({tag, "_tx_data"}, obs_q[i].data, exp_q[i].data);
    end
    cpu_rd(A_STATUS, d);
    check_eq({tag, "_status"}, d, {16'h0, 8'(e_pc), 5'h0, e_timeout, !e_timeout, 1'b0});
    cpu_rd(A_PINS, d);
    check_eq({tag, "_pins"}, d, m_pins);
    cpu_wr(A_CTRL, 32'h4);
    check_eq({tag, "_irq_clr"}, 32'(irq), 32'h0);
  endtask

  function automatic int unsigned count_reads();
    int unsigned n = 0;
    foreach (obs_q[i]) if (obs_q[i].kind) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] d;
    int unsigned n, op, gap;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_wr", 32'(g_wr), 32'h0);
    check_eq("rst_rd", 32'(g_rd), 32'h0);
    check_eq("rst_addr", 32'(g_addr), 32'd2);
    check_eq("rst_be", 32'(g_be), 32'hF);
    check_eq("rst_wdata", g_wdata, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_wait", 32'(c_wait), 32'h0);
    rst = 1'b0;
    cpu_rd(A_STATUS, d);
    check_eq("rst_status", d, 32'h0);

    // Two register writes back to back.
    p_op = '{1, 0}; p_arg = '{32'hFFFF_FFFF, 32'hA5A5_0001}; p_miss.delete();
    p_mask = 32'h0000_00F0; p_tmo = 0;
    run_prog("setw");
    cpu_rd(A_LEN, d);
    check_eq("len_rb", d, 32'd2);
    cpu_rd(A_MASK, d);
    check_eq("mask_rb", d, 32'h0000_00F0);
    cpu_rd(A_OP, d);
    check_eq("unlisted_rd", d, 32'h0);

    // DELAY 10 between two writes: 10 delay cycles plus fetch/exec of DELAY and next write.
    p_op = '{0, 2, 0}; p_arg = '{32'h1111_0000, 32'd10, 32'h2222_0000};
    run_prog("delay");
    gap = (obs_q.size() >= 2) ? obs_q[1].t - obs_q[0].t : 0;
    check_eq("delay_gap", gap, 32'd14);

    // POLL matching on the third sample.
    p_op = '{3}; p_arg = '{32'h1}; p_mask = 32'h1; p_tmo = 5; p_miss = '{2};
    run_prog("poll");
    check_eq("poll_nrd", count_reads(), 32'd3);
    cpu_rd(A_PINS, d);
    check_eq("poll_pin0", d & 32'h1, 32'h1);

    // POLL that never matches.
    p_op = '{0, 3}; p_arg = '{32'hDEAD_BEEF, 32'h1}; p_mask = 32'h1; p_tmo = 3; p_miss = '{99};
    run_prog("tmo");
    check_eq("tmo_nrd", count_reads(), 32'd4);

    // LEN=0 start completes immediately with no GPIO traffic.
    cpu_wr(A_LEN, 32'd0);
    obs_q.delete(); mon_en = 1'b1;
    cpu_wr(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check_eq("len0_ntx", obs_q.size(), 32'd0);
    check_eq("len0_irq", 32'(irq), 32'h1);
    cpu_rd(A_STATUS, d);
    check_eq("len0_status", d & 32'h7, 32'h2);
    cpu_wr(A_CTRL, 32'h4);

    // ABORT during a long DELAY; LEN write while busy must be dropped.
    p_op = '{0, 2, 0}; p_arg = '{32'h1, 32'd1000, 32'h2}; p_tmo = 0;
    load_prog();
    obs_q.delete(); mon_en = 1'b1;
    cpu_wr(A_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    cpu_wr(A_LEN, 32'd7);
    cpu_wr(A_CTRL, 32'h2);
    cpu_rd(A_STATUS, d);
    check_eq("abort_status", d & 32'h7, 32'h0);
    repeat (1100) @(negedge clk);
    mon_en = 1'b0;
    check_eq("abort_ntx", obs_q.size(), 32'd1);
    check_eq("abort_irq", 32'(irq), 32'h0);
    cpu_rd(A_LEN, d);
    check_eq("busy_len_ign", d, 32'd3);

    // Asynchronous reset in the middle of a POLL.
    p_op = '{3}; p_arg = '{32'h1}; p_mask = 32'h1; p_tmo = 200;
    load_prog();
    rd_vals.delete();
    cpu_wr(A_CTRL, 32'h1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_wr", 32'(g_wr), 32'h0);
    check_eq("mrst_rd", 32'(g_rd), 32'h0);
    check_eq("mrst_addr", 32'(g_addr), 32'd2);
    @(negedge clk);
    check_eq("mrst_rd2", 32'(g_rd), 32'h0);
    rst = 1'b0;
    m_pins = '0;
    cpu_rd(A_STATUS, d);
    check_eq("mrst_status", d, 32'h0);
    check_eq("mrst_irq", 32'(irq), 32'h0);

    // Random programs.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(8, 1);
      p_op.delete(); p_arg.delete(); p_miss.delete();
      p_mask = $urandom();
      if (p_mask == 0) p_mask = 32'h1;
      p_tmo = $urandom_range(4, 0);
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(3, 0);
        p_op.push_back(op);
        if (op == 2) p_arg.push_back($urandom_range(15, 0));
        else p_arg.push_back($urandom());
        if (op == 3) p_miss.push_back($urandom_range(p_tmo + 1, 0));
      end
      run_prog("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
